// File: rtl/mips_pkg.sv
// Shared constants for the 16-bit pipelined MIPS datapath.
// Forwarding select encodings used by the decode-stage operand muxes.
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_DM  = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

endpackage

// File: rtl/reg_file_32x16.sv
// General register storage: two async read ports, one sync write port.
// R0 is hardwired to zero; the write port has no enable.
module reg_file_32x16
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (rw != '0) begin
            mem[rw] <= wd;
        end
    end

    // Reads see the pre-edge contents; same-edge bypass lives in the top.
    assign rd_a = (ra == '0) ? '0 : mem[ra];
    assign rd_b = (rb == '0) ? '0 : mem[rb];

endmodule

// File: rtl/register_bank_block.sv
// Decode-stage register bank with EX/DM/WB forwarding and immediate
// override on B; operands registered into the ID/EX boundary.
module register_bank_block
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [DATA_W-1:0] imm,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic [1:0]        mux_sel_A,
    input  logic [1:0]        mux_sel_B,
    input  logic              imm_sel,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] b_next;

    reg_file_32x16 #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra  (RA),
        .rb  (RB),
        .rw  (RW_dm),
        .wd  (ans_dm),
        .rd_a(r_a),
        .rd_b(r_b)
    );

    always_comb begin
        fwd_a = r_a;
        unique case (mux_sel_A)
            SEL_REG: fwd_a = r_a;
            SEL_EX:  fwd_a = ans_ex;
            SEL_DM:  fwd_a = ans_dm;
            SEL_WB:  fwd_a = ans_wb;
            default: fwd_a = r_a;
        endcase
    end

    always_comb begin
        fwd_b = r_b;
        unique case (mux_sel_B)
            SEL_REG: fwd_b = r_b;
            SEL_EX:  fwd_b = ans_ex;
            SEL_DM:  fwd_b = ans_dm;
            SEL_WB:  fwd_b = ans_wb;
            default: fwd_b = r_b;
        endcase
    end

    assign b_next = imm_sel ? imm : fwd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            A <= '0;
            B <= '0;
        end else begin
            A <= fwd_a;
            B <= b_next;
        end
    end

endmodule

// File: tb/tb_register_bank_block.sv
// Scoreboard bench for register_bank_block: directed plan plus random
// traffic checked against an array-based reference model.
module tb_register_bank_block;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ans_ex, ans_dm, ans_wb, imm;
    logic [4:0]  RA, RB, RW_dm;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic        imm_sel;
    logic [15:0] A, B;

    always #5 clk = ~clk;

    register_bank_block dut (
        .clk      (clk),
        .rst      (rst),
        .ans_ex   (ans_ex),
        .ans_dm   (ans_dm),
        .ans_wb   (ans_wb),
        .imm      (imm),
        .RA       (RA),
        .RB       (RB),
        .RW_dm    (RW_dm),
        .mux_sel_A(mux_sel_A),
        .mux_sel_B(mux_sel_B),
        .imm_sel  (imm_sel),
        .A        (A),
        .B        (B)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        string       tag;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model_mem [32];
    int          total = 0;
    int          bad = 0;

    function automatic logic [15:0] pick(input logic [1:0] sel,
                                         input logic [15:0] rd,
                                         input logic [15:0] ex,
                                         input logic [15:0] dm,
                                         input logic [15:0] wb);
        logic [15:0] src [4];
        src[0] = rd;
        src[1] = ex;
        src[2] = dm;
        src[3] = wb;
        return src[sel];
    endfunction

    task automatic step(input logic r, input logic [15:0] ex,
                        input logic [15:0] dm, input logic [15:0] wb,
                        input logic [15:0] im, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] rw,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input logic isel, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; ans_ex = ex; ans_dm = dm; ans_wb = wb; imm = im;
        RA = ra; RB = rb; RW_dm = rw;
        mux_sel_A = sa; mux_sel_B = sb; imm_sel = isel;
        e.tag = tag;
        if (r) begin
            e.a = 16'h0;
            e.b = 16'h0;
            for (int i = 0; i < 32; i++) model_mem[i] = 16'h0;
        end else begin
            e.a = pick(sa, model_mem[ra], ex, dm, wb);
            e.b = isel ? im : pick(sb, model_mem[rb], ex, dm, wb);
            if (rw != 0) model_mem[rw] = dm;
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (A !== e.a) begin
                    bad++;
                    $display("FAIL %s A got=%h want=%h", e.tag, A, e.a);
                end
                total++;
                if (B !== e.b) begin
                    bad++;
                    $display("FAIL %s B got=%h want=%h", e.tag, B, e.b);
                end
            end
        end
    end

    initial begin : stim
        logic [1:0] s;
        int wait_cyc;
        rst = 0; ans_ex = 0; ans_dm = 0; ans_wb = 0; imm = 0;
        RA = 0; RB = 0; RW_dm = 0;
        mux_sel_A = 0; mux_sel_B = 0; imm_sel = 0;

        step(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
             5'd3, 5'd9, 5'd4, 2'b01, 2'b10, 1'b0, "reset");
        for (int i = 1; i < 32; i++)
            step(0, 0, 0, 0, 0, 5'(i), 5'(32 - i), 5'd0,
                 2'b00, 2'b00, 1'b0, "reset_clear");

        step(0, 0, 16'hD000, 0, 0, 5'd0, 5'd0, 5'd7,
             2'b00, 2'b00, 1'b0, "wr7");
        step(0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd0,
             2'b00, 2'b00, 1'b0, "rd7");

        step(0, 16'hC000, 16'hD000, 16'hE000, 0, 5'd1, 5'd7, 5'd0,
             2'b10, 2'b01, 1'b0, "fwd_dm_ex");
        step(0, 16'hC000, 16'hD000, 16'hE000, 0, 5'd1, 5'd7, 5'd0,
             2'b11, 2'b00, 1'b0, "fwd_wb_reg");

        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            step(0, 16'hC000, 16'hD000, 16'hE000, 16'hFFFF, 5'd7, 5'd7,
                 5'd0, s, s, 1'b1, "imm_sweep");
        end

        step(0, 0, 16'h1234, 0, 0, 5'd0, 5'd0, 5'd0,
             2'b00, 2'b00, 1'b0, "r0_wr");
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0,
             2'b00, 2'b00, 1'b0, "r0_rd");

        step(0, 0, 16'hABCD, 0, 0, 5'd5, 5'd5, 5'd5,
             2'b00, 2'b00, 1'b0, "raw_old");
        step(0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd0,
             2'b00, 2'b00, 1'b0, "raw_new");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                 "random");
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
